// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, op encoding, trap cause codes and status bit indices
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int IRQ_MTI_BIT  = 7;
    localparam int IRQ_MEI_BIT  = 11;

endpackage

// File: rtl/csr_trap_unit_if.sv
// rtl/csr_trap_unit_if.sv - CSR instruction access bus between pipeline and CSR file
interface csr_trap_unit_if #(
    parameter int XLEN = 32
);
    logic            csr_wr;
    logic [1:0]      csr_op;
    logic [11:0]     addr_csr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            illegal_csr;

    modport master (
        output csr_wr, csr_op, addr_csr, csr_wdata,
        input  csr_rdata, illegal_csr
    );

    modport slave (
        input  csr_wr, csr_op, addr_csr, csr_wdata,
        output csr_rdata, illegal_csr
    );
endinterface

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit free/enabled counter with independent 32-bit half writes
module csr_counter64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_count
);
    logic [63:0] r_count;
    logic [63:0] w_next;

    // A written half takes the CSR value; the other half keeps the increment (and its carry).
    assign w_next = r_count + {63'd0, i_inc};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count[31:0]  <= i_wr_lo ? i_wdata : w_next[31:0];
            r_count[63:32] <= i_wr_hi ? i_wdata : w_next[63:32];
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file with interrupt trap entry and MRET return
// Optional mcycle/minstret counters enabled by defining CSR_COUNTERS_EN.
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter bit              VECTORED  = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    csr_trap_unit_if.slave  bus,
    input  logic [XLEN-1:0] PC_MW,
    input  logic            is_mret,
    input  logic            ext_irq,
    input  logic            timer_irq,
    input  logic            instr_ret,
    output logic            trap_taken,
    output logic [XLEN-1:0] epc_evec
);
    localparam logic [XLEN-1:0] MTVEC_RST_M =
        VECTORED ? MTVEC_RST : {MTVEC_RST[XLEN-1:2], 2'b00};

    logic            r_mst_mie, r_mst_mpie;
    logic            r_mie_mtie, r_mie_meie;
    logic            r_mip_mtip, r_mip_meip;
    logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause;

    logic            w_irq_mei, w_irq_mti, w_irq_req;
    logic [3:0]      w_cause;
    logic [XLEN-1:0] w_base;
    logic            w_vec;
    logic [XLEN-1:0] w_rdata, w_new;
    logic            w_impl, w_wr_en;

`ifdef CSR_COUNTERS_EN
    logic [63:0] w_mcycle, w_minstret;

    csr_counter64 u_mcycle (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (1'b1),
        .i_wr_lo (w_wr_en && bus.addr_csr == CSR_MCYCLE),
        .i_wr_hi (w_wr_en && bus.addr_csr == CSR_MCYCLEH),
        .i_wdata (w_new[31:0]),
        .o_count (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (instr_ret),
        .i_wr_lo (w_wr_en && bus.addr_csr == CSR_MINSTRET),
        .i_wr_hi (w_wr_en && bus.addr_csr == CSR_MINSTRETH),
        .i_wdata (w_new[31:0]),
        .o_count (w_minstret)
    );
`else
    logic w_unused_instr_ret;
    assign w_unused_instr_ret = instr_ret;
`endif

    assign w_irq_mei = r_mst_mie & r_mie_meie & r_mip_meip;
    assign w_irq_mti = r_mst_mie & r_mie_mtie & r_mip_mtip;
    assign w_irq_req = w_irq_mei | w_irq_mti;
    assign w_cause   = w_irq_mei ? CAUSE_MEI : CAUSE_MTI;
    assign w_base    = {r_mtvec[XLEN-1:2], 2'b00};
    assign w_vec     = VECTORED && (r_mtvec[1:0] != 2'b00);

    always_comb begin
        trap_taken = w_irq_req | is_mret;
        epc_evec   = '0;
        if (w_irq_req) begin
            epc_evec = w_vec ? w_base + XLEN'({w_cause, 2'b00}) : w_base;
        end else if (is_mret) begin
            epc_evec = r_mepc;
        end
    end

    always_comb begin
        w_rdata = '0;
        w_impl  = 1'b1;
        case (bus.addr_csr)
            CSR_MSTATUS: begin
                w_rdata[MSTATUS_MIE]  = r_mst_mie;
                w_rdata[MSTATUS_MPIE] = r_mst_mpie;
                w_rdata[12:11]        = 2'b11;
            end
            CSR_MIE: begin
                w_rdata[IRQ_MTI_BIT] = r_mie_mtie;
                w_rdata[IRQ_MEI_BIT] = r_mie_meie;
            end
            CSR_MTVEC:    w_rdata = r_mtvec;
            CSR_MSCRATCH: w_rdata = r_mscratch;
            CSR_MEPC:     w_rdata = r_mepc;
            CSR_MCAUSE:   w_rdata = r_mcause;
            CSR_MIP: begin
                w_rdata[IRQ_MTI_BIT] = r_mip_mtip;
                w_rdata[IRQ_MEI_BIT] = r_mip_meip;
            end
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    w_rdata = XLEN'(w_mcycle[31:0]);
            CSR_MCYCLEH:   w_rdata = XLEN'(w_mcycle[63:32]);
            CSR_MINSTRET:  w_rdata = XLEN'(w_minstret[31:0]);
            CSR_MINSTRETH: w_rdata = XLEN'(w_minstret[63:32]);
`endif
            default: w_impl = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op_e'(bus.csr_op))
            CSR_OP_WRITE: w_new = bus.csr_wdata;
            CSR_OP_SET:   w_new = w_rdata | bus.csr_wdata;
            CSR_OP_CLEAR: w_new = w_rdata & ~bus.csr_wdata;
            default:      w_new = w_rdata;
        endcase
    end

    // An interrupt taken this cycle squashes the CSR instruction's write.
    assign w_wr_en = bus.csr_wr && (bus.csr_op != CSR_OP_NONE) && w_impl && !w_irq_req;

    assign bus.csr_rdata   = w_rdata;
    assign bus.illegal_csr = bus.csr_wr & ~w_impl;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mst_mie  <= 1'b0;
            r_mst_mpie <= 1'b0;
            r_mie_mtie <= 1'b0;
            r_mie_meie <= 1'b0;
            r_mip_mtip <= 1'b0;
            r_mip_meip <= 1'b0;
            r_mtvec    <= MTVEC_RST_M;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
        end else begin
            r_mip_meip <= ext_irq;
            r_mip_mtip <= timer_irq;
            if (w_irq_req) begin
                r_mepc     <= {PC_MW[XLEN-1:2], 2'b00};
                r_mcause   <= {1'b1, (XLEN-1)'(w_cause)};
                r_mst_mpie <= r_mst_mie;
                r_mst_mie  <= 1'b0;
            end else begin
                if (w_wr_en) begin
                    case (bus.addr_csr)
                        CSR_MSTATUS: if (!is_mret) begin
                            r_mst_mie  <= w_new[MSTATUS_MIE];
                            r_mst_mpie <= w_new[MSTATUS_MPIE];
                        end
                        CSR_MIE: begin
                            r_mie_mtie <= w_new[IRQ_MTI_BIT];
                            r_mie_meie <= w_new[IRQ_MEI_BIT];
                        end
                        CSR_MTVEC:    r_mtvec    <= VECTORED ? w_new : {w_new[XLEN-1:2], 2'b00};
                        CSR_MSCRATCH: r_mscratch <= w_new;
                        CSR_MEPC:     r_mepc     <= {w_new[XLEN-1:2], 2'b00};
                        CSR_MCAUSE:   r_mcause   <= w_new;
                        default: ;
                    endcase
                end
                if (is_mret) begin
                    r_mst_mie  <= r_mst_mpie;
                    r_mst_mpie <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - directed and randomized checks of csr_trap_unit against a CSR-level model
module tb_csr_trap_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_MW;
    logic        is_mret, ext_irq, timer_irq, instr_ret;
    logic        trap_taken;
    logic [31:0] epc_evec;

    csr_trap_unit_if #(.XLEN(32)) bus ();

    csr_trap_unit #(.XLEN(32), .MTVEC_RST(32'h0), .VECTORED(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .PC_MW      (PC_MW),
        .is_mret    (is_mret),
        .ext_irq    (ext_irq),
        .timer_irq  (timer_irq),
        .instr_ret  (instr_ret),
        .trap_taken (trap_taken),
        .epc_evec   (epc_evec)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Architectural state of the model: mstatus holds only MIE/MPIE bits.
    logic [31:0] m_mst, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip;
    logic [63:0] m_cyc, m_ret;

    logic [31:0] s_rdata, s_evec;
    logic        s_ill, s_trap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mst = 0; m_mie = 0; m_mtvec = 32'h0; m_mscratch = 0;
        m_mepc = 0; m_mcause = 0; m_mip = 0; m_cyc = 0; m_ret = 0;
    endtask

    task automatic m_read(input logic [11:0] a, output logic [31:0] v, output bit ok);
        ok = 1'b1;
        v  = 32'h0;
        case (a)
            12'h300: v = m_mst | 32'h1800;
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h344: v = m_mip;
`ifdef CSR_COUNTERS_EN
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB02: v = m_ret[31:0];
            12'hB82: v = m_ret[63:32];
`endif
            default: ok = 1'b0;
        endcase
    endtask

    function automatic int m_cause();
        logic [31:0] p;
        p = m_mie & m_mip;
        if (!m_mst[3]) return -1;
        if (p[11]) return 11;
        if (p[7]) return 7;
        return -1;
    endfunction

    task automatic m_step();
        logic [31:0] old, res;
        logic [31:0] n_mst, n_mie, n_mtvec, n_mscratch, n_mepc, n_mcause;
        logic [63:0] n_cyc, n_ret;
        bit ok;
        int c;
        if (reset) begin
            m_reset();
            return;
        end
        c = m_cause();
        m_read(bus.addr_csr, old, ok);
        case (bus.csr_op)
            2'b01:   res = bus.csr_wdata;
            2'b10:   res = old | bus.csr_wdata;
            default: res = old & ~bus.csr_wdata;
        endcase
        n_mst = m_mst; n_mie = m_mie; n_mtvec = m_mtvec; n_mscratch = m_mscratch;
        n_mepc = m_mepc; n_mcause = m_mcause;
        n_cyc = m_cyc + 64'd1;
        n_ret = m_ret + {63'd0, instr_ret};
        if (bus.csr_wr && bus.csr_op != 2'b00 && ok && c < 0) begin
            case (bus.addr_csr)
                12'h300: if (!is_mret) n_mst = res & 32'h88;
                12'h304: n_mie = res & 32'h880;
                12'h305: n_mtvec = res;
                12'h340: n_mscratch = res;
                12'h341: n_mepc = res & ~32'h3;
                12'h342: n_mcause = res;
                12'hB00: n_cyc[31:0] = res;
                12'hB80: n_cyc[63:32] = res;
                12'hB02: n_ret[31:0] = res;
                12'hB82: n_ret[63:32] = res;
                default: ;
            endcase
        end
        if (c >= 0) begin
            n_mepc   = PC_MW & ~32'h3;
            n_mcause = 32'h8000_0000 | c;
            n_mst    = m_mst[3] ? 32'h80 : 32'h0;
        end else if (is_mret) begin
            n_mst = 32'h80 | (m_mst[7] ? 32'h8 : 32'h0);
        end
        m_mst = n_mst; m_mie = n_mie; m_mtvec = n_mtvec; m_mscratch = n_mscratch;
        m_mepc = n_mepc; m_mcause = n_mcause; m_cyc = n_cyc; m_ret = n_ret;
        m_mip = (ext_irq ? 32'h800 : 32'h0) | (timer_irq ? 32'h80 : 32'h0);
    endtask

    // One clock: inputs already driven; compare at negedge, then advance the model with the edge.
    task automatic cycle();
        logic [31:0] e_rd, e_evec;
        logic        e_trap;
        bit ok;
        int c;
        @(negedge clk);
        m_read(bus.addr_csr, e_rd, ok);
        c = m_cause();
        if (c >= 0) begin
            e_trap = 1'b1;
            e_evec = (m_mtvec & ~32'h3) + (((m_mtvec & 32'h3) != 0) ? 32'(4 * c) : 32'h0);
        end else if (is_mret) begin
            e_trap = 1'b1;
            e_evec = m_mepc;
        end else begin
            e_trap = 1'b0;
            e_evec = 32'h0;
        end
        s_rdata = bus.csr_rdata;
        s_ill   = bus.illegal_csr;
        s_trap  = trap_taken;
        s_evec  = epc_evec;
        chk("rdata", s_rdata, e_rd);
        chk("illegal", {31'd0, s_ill}, {31'd0, bus.csr_wr & ~ok});
        chk("trap_taken", {31'd0, s_trap}, {31'd0, e_trap});
        chk("epc_evec", s_evec, e_evec);
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic op_cyc(input bit wr, input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        bus.csr_wr    = wr;
        bus.csr_op    = op;
        bus.addr_csr  = a;
        bus.csr_wdata = wd;
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] rst_addrs [7];
        logic [11:0] rnd_addrs [12];
        logic [31:0] exp_rst;
        rst_addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344};
        rnd_addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                      12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0};

        reset = 1'b1; PC_MW = 0; is_mret = 0; ext_irq = 0; timer_irq = 0; instr_ret = 0;
        bus.csr_wr = 0; bus.csr_op = 0; bus.addr_csr = 12'h300; bus.csr_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();

        for (int i = 0; i < 7; i++) begin
            op_cyc(0, 2'b00, rst_addrs[i], 32'h0);
            exp_rst = (rst_addrs[i] == 12'h300) ? 32'h0000_1800 : 32'h0;
            chk("reset_read", s_rdata, exp_rst);
        end
        chk("reset_trap", {31'd0, s_trap}, 32'd0);

        op_cyc(1, 2'b01, 12'h340, 32'hA5A5_0000); chk("scratch_old0", s_rdata, 32'h0);
        op_cyc(1, 2'b10, 12'h340, 32'h0000_00FF); chk("scratch_old1", s_rdata, 32'hA5A5_0000);
        op_cyc(1, 2'b11, 12'h340, 32'hA500_0000); chk("scratch_old2", s_rdata, 32'hA5A5_00FF);
        op_cyc(0, 2'b00, 12'h340, 32'h0);         chk("scratch_final", s_rdata, 32'h00A5_00FF);
        chk("model_scratch", m_mscratch, 32'h00A5_00FF);

        op_cyc(1, 2'b01, 12'h305, 32'h100);
        op_cyc(1, 2'b01, 12'h304, 32'h800);
        op_cyc(1, 2'b10, 12'h300, 32'h8);
        PC_MW = 32'h40; ext_irq = 1;
        op_cyc(0, 2'b00, 12'h341, 0); chk("mei_latency", {31'd0, s_trap}, 32'd0);
        op_cyc(0, 2'b00, 12'h341, 0); chk("mei_trap", {31'd0, s_trap}, 32'd1);
        chk("mei_evec", s_evec, 32'h100);
        ext_irq = 0;
        op_cyc(0, 2'b00, 12'h341, 0); chk("mepc", s_rdata, 32'h40);
        op_cyc(0, 2'b00, 12'h342, 0); chk("mcause", s_rdata, 32'h8000_000B);
        op_cyc(0, 2'b00, 12'h300, 0); chk("mstatus_trap", s_rdata, 32'h0000_1880);
        is_mret = 1;
        op_cyc(0, 2'b00, 12'h341, 0); chk("mret_evec", s_evec, 32'h40);
        is_mret = 0;
        op_cyc(0, 2'b00, 12'h300, 0); chk("mstatus_mret", s_rdata, 32'h0000_1888);

        op_cyc(1, 2'b01, 12'h305, 32'h101);
        op_cyc(1, 2'b01, 12'h304, 32'h80);
        timer_irq = 1;
        op_cyc(0, 2'b00, 12'h300, 0);
        op_cyc(0, 2'b00, 12'h300, 0); chk("mti_vec_evec", s_evec, 32'h11C);
        timer_irq = 0;
        op_cyc(1, 2'b01, 12'h304, 32'h880);
        op_cyc(0, 2'b00, 12'h300, 0);
        ext_irq = 1; timer_irq = 1;
        op_cyc(0, 2'b00, 12'h300, 0);
        is_mret = 1;
        op_cyc(0, 2'b00, 12'h300, 0);
        PC_MW = 32'h80;
        op_cyc(1, 2'b01, 12'h340, 32'hDEAD_BEEF); chk("both_vec_evec", s_evec, 32'h12C);
        is_mret = 0; ext_irq = 0; timer_irq = 0;
        op_cyc(0, 2'b00, 12'h341, 0); chk("trap_beats_mret_mepc", s_rdata, 32'h80);
        op_cyc(0, 2'b00, 12'h340, 0); chk("trap_drops_write", s_rdata, 32'h00A5_00FF);
        is_mret = 1;
        op_cyc(1, 2'b01, 12'h300, 32'h0);
        is_mret = 0;
        op_cyc(0, 2'b00, 12'h300, 0); chk("mret_beats_mstatus_wr", s_rdata, 32'h0000_1888);

        op_cyc(1, 2'b01, 12'h7C0, 32'hFFFF_FFFF); chk("illegal_flag", {31'd0, s_ill}, 32'd1);
        chk("illegal_rdata", s_rdata, 32'h0);
        op_cyc(0, 2'b00, 12'h7C0, 0); chk("illegal_no_wr", {31'd0, s_ill}, 32'd0);

`ifdef CSR_COUNTERS_EN
        op_cyc(1, 2'b01, 12'hB00, 32'hFFFF_FFFF);
        op_cyc(0, 2'b00, 12'hB00, 0); chk("mcycle_written", s_rdata, 32'hFFFF_FFFF);
        op_cyc(0, 2'b00, 12'hB00, 0); chk("mcycle_wrap", s_rdata, 32'h0);
        op_cyc(0, 2'b00, 12'hB80, 0);
`else
        op_cyc(1, 2'b01, 12'hB00, 32'h5); chk("mcycle_absent", {31'd0, s_ill}, 32'd1);
`endif

        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            is_mret   = ($urandom_range(0, 7) == 0);
            ext_irq   = ($urandom_range(0, 3) == 0);
            timer_irq = ($urandom_range(0, 3) == 0);
            instr_ret = $urandom_range(0, 1);
            PC_MW     = $urandom;
            op_cyc($urandom_range(0, 1), 2'($urandom_range(0, 3)),
                   rnd_addrs[$urandom_range(0, 11)], $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Parametrised machine-mode CSR file with trap sequencing; successor to the single-write CSR register file.
- Adds atomic CSR ops (write/set/clear), registered interrupt pending, mstatus MIE/MPIE stacking, MRET return, and vectored mtvec.
- Sits beside the pipeline's memory/writeback stage; drives the PC redirect target (epc_evec) and flush request (trap_taken).

Parameters:
- XLEN, 32, data width of CSRs and PC.
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.
- VECTORED, 1, 1 allows mtvec.MODE=1 vectored interrupts; 0 forces MODE bits to read 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- csr_wr  in  1  CSR instruction in M/W stage this cycle
- csr_op  in  2  00 none, 01 write, 10 set, 11 clear
- addr_csr  in  12  CSR address
- csr_wdata  in  XLEN  rs1/uimm operand
- csr_rdata  out  XLEN  combinational read of addr_csr (old value)
- illegal_csr  out  1  addr_csr unimplemented while csr_wr=1
- PC_MW  in  XLEN  PC of instruction in M/W stage
- is_mret  in  1  MRET in M/W stage
- ext_irq  in  1  external interrupt level
- timer_irq  in  1  timer interrupt level
- instr_ret  in  1  instruction retired this cycle
- trap_taken  out  1  combinational redirect/flush request
- epc_evec  out  XLEN  redirect target

Behaviour:
- Implemented CSRs: mstatus 300 (MIE bit3, MPIE bit7, MPP[12:11] reads 2'b11), mie 304 (MTIE bit7, MEIE bit11), mtvec 305, mscratch 340, mepc 341 (bits[1:0] read 0), mcause 342, mip 344 (read-only MTIP bit7, MEIP bit11).
- Reset: mstatus MIE=0, MPIE=0; mie=0; mtvec=MTVEC_RST; mscratch, mepc, mcause=0; mip=0; trap_taken=0; epc_evec=0.
- mip registered: mip.MEIP<=ext_irq, mip.MTIP<=timer_irq each cycle. One cycle latency from input to pending.
- irq_req = mstatus.MIE & |(mie & mip). Priority: MEIP (cause 11) over MTIP (cause 7).
- Read: csr_rdata combinational, returns the pre-write value. Unimplemented address: rdata=0, illegal_csr=1, no state change.
- Write: at posedge when csr_wr and csr_op!=00. write: new=wdata; set: new=old|wdata; clear: new=old&~wdata. Only writable bits update.
- Trap entry when irq_req=1, same cycle combinationally:
  - trap_taken=1.
  - epc_evec=base if MODE=0; otherwise base+4*cause, where base={mtvec[XLEN-1:2],2'b00}.
  - Next edge: mepc<=PC_MW; mcause<={1'b1,cause}; MPIE<=MIE; MIE<=0.
- MRET, when is_mret and no irq_req: trap_taken=1, epc_evec=mepc. Next edge: MIE<=MPIE, MPIE<=1.
- Otherwise trap_taken=0 and epc_evec=0.
- Simultaneous events:
  - Trap beats MRET; mepc<=PC_MW.
  - Trap beats CSR write; the write is dropped.
  - MRET with a CSR write to mstatus: MRET wins. Writes to other CSRs proceed.
- No state machine beyond CSR state; trap is a one-cycle event. The pipeline must flush, so a repeat trap only occurs if MIE is re-enabled.
- Reset mid-trap: reset has priority over all updates.

Optional Feature:
- CSR_COUNTERS_EN defined:
  - Adds 64-bit mcycle (B00 low, B80 high) and minstret (B02, B82).
  - mcycle increments every cycle; minstret increments when instr_ret.
  - A CSR write to a half wins over the increment that cycle; the other half still follows the increment.
  - Carry propagates low to high; wrap from all-ones to 0.
  - Reset 0.
- CSR_COUNTERS_EN undefined: these addresses are unimplemented (illegal_csr=1, rdata 0).

Decomposition:
- Package csr_pkg: CSR address localparams, csr_op_e enum, cause codes (CAUSE_MEI=11, CAUSE_MTI=7), mstatus bit indices.
- One sub-module, csr_counter64: a parametric 64-bit counter with enable and half-word write ports, instantiated twice under CSR_COUNTERS_EN.

Test Plan:
- Reset; read each CSR. Expect mtvec=MTVEC_RST, all others 0, mstatus reads 32'h0000_1800, trap_taken=0.
- Write mscratch 32'hA5A5_0000, set 32'h0000_00FF, clear 32'hA500_0000. Expect rdata 32'h00A5_00FF; rdata shows the old value during each op cycle.
- mtvec=32'h100, mie.MEIE=1, MIE=1, ext_irq=1 with PC_MW=32'h40. Expect trap one cycle after mip, epc_evec=32'h100, mepc=32'h40, mcause=32'h8000_000B, MIE=0, MPIE=1.
- mtvec=32'h101 (vectored), mie.MTIE=1, timer_irq=1. Expect epc_evec=32'h11C; with ext+timer both pending and enabled, epc_evec=32'h12C.
- MRET after trap: trap_taken=1, epc_evec=mepc, then MIE=1, MPIE=1. MRET and irq in the same cycle: trap wins, mepc=PC_MW.
- Access 12'h7C0: illegal_csr=1, rdata 0, no update. With CSR_COUNTERS_EN, write mcycle low 32'hFFFF_FFFF; next cycle low=0 and high incremented by 1.
